// File: rtl/ps2_code_assembler.sv
// ps2_code_assembler
//   Turns a stream of validated PS/2 set-2 scan bytes into key events
//   {code, ext, brk}. E0 marks an extended key, F0 marks a key release.
//   Events are queued in a DEPTH-entry FIFO with a ready/valid output.
//   disp carries {prefix, code} of the most recently assembled event
//   for the 7-segment hex stage.
//   ovf is sticky once an event is lost to a full FIFO.
//
//   Optional feature: define ASM_TIMEOUT_EN to abandon a half-received
//   prefix sequence after TIMEOUT_CYC idle clocks.
module ps2_code_assembler #(
    parameter int DEPTH = 4
`ifdef ASM_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1_500_000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        byte_err,
    output logic [7:0]  ev_code,
    output logic        ev_ext,
    output logic        ev_brk,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [15:0] disp,
    output logic        ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXTBRK
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    state_t        state;
    state_t        state_nxt;
    logic          accepted;
    logic          rejected;
    logic          timeout;
    logic          push_req;
    ev_t           push_ev;
    logic          in_ext;
    logic          in_brk;

    ev_t           mem [DEPTH];
    ev_t           head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          do_push;

    assign accepted = byte_valid & ~byte_err;
    assign rejected = byte_valid & byte_err;

`ifdef ASM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] tmo_cnt;

    // Idle-time counter for a pending prefix; any accepted byte restarts it.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || accepted) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign timeout = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // The prefix state alone tells which flags the final byte carries.
    assign in_ext = (state == EXT) || (state == EXTBRK);
    assign in_brk = (state == BRK) || (state == EXTBRK);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments.
        // All flops then sample pre-edge values regardless of block order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and emit decode; an accepted byte takes priority over a timeout.
    always_comb begin
        // NOTE: every output of this block is defaulted first.
        // An incomplete assignment path would otherwise infer a latch.
        state_nxt = state;
        push_req  = 1'b0;
        push_ev   = {byte_data, in_ext, in_brk};
        if (accepted) begin
            if (byte_data == CODE_EXT) begin
                // A fresh E0 always restarts as an extended sequence.
                // Any pending break is dropped.
                state_nxt = EXT;
            end else if (byte_data == CODE_BRK) begin
                state_nxt = in_ext ? EXTBRK : BRK;
            end else begin
                push_req  = 1'b1;
                state_nxt = IDLE;
            end
        end else if (rejected || timeout) begin
            state_nxt = IDLE;
        end
    end

    assign ev_valid = (count != '0);
    assign full     = (count == FULL_CNT);
    assign pop      = ev_valid & ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = push_req & (~full | pop);

    // Event storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset.
        // Outputs are masked while the FIFO is empty, so stale contents are never visible.
        if (do_push) begin
            mem[wr_ptr] <= push_ev;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Display word and sticky overflow flag.
    // disp tracks every emit, including events dropped on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp <= 16'h0000;
            ovf  <= 1'b0;
        end else begin
            if (push_req) begin
                if (push_ev.brk) begin
                    disp <= {CODE_BRK, push_ev.code};
                end else if (push_ev.ext) begin
                    disp <= {CODE_EXT, push_ev.code};
                end else begin
                    disp <= {8'h00, push_ev.code};
                end
            end
            if (push_req && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];
    assign {ev_code, ev_ext, ev_brk} = ev_valid ? head : '0;

endmodule

// File: tb/tb_ps2_code_assembler.sv
// tb_ps2_code_assembler
//   Directed bench for ps2_code_assembler.
//   Stimulus pushes hand-computed events into a scoreboard queue.
//   A negedge monitor pops the queue and compares it against each accepted FIFO head.
//   Define ASM_TIMEOUT_EN to include the prefix-timeout cases (TIMEOUT_CYC=100).
module tb_ps2_code_assembler;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_err;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_brk;
    logic        ev_valid;
    logic        ev_ready;
    logic [15:0] disp;
    logic        ovf;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    ps2_code_assembler #(
        .DEPTH(DEPTH)
`ifdef ASM_TIMEOUT_EN
        , .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_brk    (ev_brk),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .disp      (disp),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each accepted head with the oldest expected event.
    always @(negedge clk) begin
        ev_t e;
        if (rst === 1'b0 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got %0h/%0b/%0b expected none",
                         ev_code, ev_ext, ev_brk);
            end else begin
                e = exp_q.pop_front();
                check("event", {22'b0, ev_code, ev_ext, ev_brk}, {22'b0, e});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle byte strobe; called at posedge+1, returns at posedge+1.
    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        byte_data  = b;
        byte_err   = err;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
    endtask

    task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
        exp_q.push_back({code, ext, brk});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        ev_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            idle(1);
        end
        check(name, exp_q.size(), 0);
        check({name, "_empty"}, ev_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        ev_ready   = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Reset state.
        check("rst_valid", ev_valid, 1'b0);
        check("rst_code", ev_code, 8'h00);
        check("rst_ext", ev_ext, 1'b0);
        check("rst_brk", ev_brk, 1'b0);
        check("rst_disp", disp, 16'h0000);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        idle(1);

        // Plain byte: one event, valid one cycle after the sampling edge.
        check("t1_valid_before", ev_valid, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        check("t1_valid_latency", ev_valid, 1'b1);
        check("t1_disp", disp, 16'h001C);
        idle(2);

        // Break and extended-break sequences.
        expect_ev(8'h1C, 1'b0, 1'b1);
        send(8'hF0);
        send(8'h1C);
        check("t2_disp_brk", disp, 16'hF01C);
        expect_ev(8'h75, 1'b1, 1'b1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("t2_disp_extbrk", disp, 16'hF075);

        // Error byte abandons the E0 prefix.
        expect_ev(8'h75, 1'b0, 1'b0);
        send(8'hE0);
        send(8'h75, 1'b1);
        send(8'h75);
        check("t3_disp", disp, 16'h0075);

        // E0 after F0 restarts an extended make.
        expect_ev(8'h12, 1'b1, 1'b0);
        send(8'hF0);
        send(8'hE0);
        send(8'h12);
        check("brk_restart_disp", disp, 16'hE012);

        // Repeated prefixes are absorbed.
        expect_ev(8'h14, 1'b1, 1'b1);
        send(8'hE0);
        send(8'hE0);
        send(8'hF0);
        send(8'hF0);
        send(8'h14);

        // E1 and AA are plain codes.
        expect_ev(8'hE1, 1'b0, 1'b0);
        send(8'hE1);
        expect_ev(8'hAA, 1'b0, 1'b0);
        send(8'hAA);

        // Error byte abandons the F0 prefix too.
        expect_ev(8'h33, 1'b0, 1'b0);
        send(8'hF0);
        send(8'h33, 1'b1);
        send(8'h33);
        drain("drain_basic");

        // Overflow: five pushes into a stalled 4-entry FIFO.
        ev_ready = 1'b0;
        for (int i = 1; i <= 4; i++) expect_ev(8'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) send(8'(i));
        check("t4_ovf", ovf, 1'b1);
        check("t4_head", ev_code, 8'h01);
        check("t4_disp_dropped", disp, 16'h0005);
        idle(3);
        check("t4_head_stable", ev_code, 8'h01);
        drain("drain_ovf");
        check("t4_ovf_sticky", ovf, 1'b1);
        do_reset();
        check("t4_ovf_cleared", ovf, 1'b0);
        idle(1);

        // Full FIFO with simultaneous push and pop.
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_ev(8'h11 + 8'(i), 1'b0, 1'b0);
            send(8'h11 + 8'(i));
        end
        check("t5_ovf_full", ovf, 1'b0);
        expect_ev(8'h15, 1'b0, 1'b0);
        byte_data  = 8'h15;
        byte_valid = 1'b1;
        ev_ready   = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        ev_ready   = 1'b0;
        check("t5_ovf_pushpop", ovf, 1'b0);
        check("t5_head_after_pop", ev_code, 8'h12);
        // Still full: one more push must be dropped.
        send(8'h16);
        check("t5_ovf_still_full", ovf, 1'b1);
        drain("drain_pushpop");
        do_reset();
        idle(1);

        // Reset mid-sequence discards the pending EXTBRK state.
        send(8'hE0);
        send(8'hF0);
        do_reset();
        idle(1);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        drain("drain_midseq");

        // Reset with a queued event empties the FIFO.
        ev_ready = 1'b0;
        send(8'h2A);
        do_reset();
        check("rst_flush_valid", ev_valid, 1'b0);
        check("rst_flush_disp", disp, 16'h0000);
        ev_ready = 1'b1;
        idle(3);

`ifdef ASM_TIMEOUT_EN
        // A byte on the timeout cycle itself wins: the E0 still applies.
        expect_ev(8'h1C, 1'b1, 1'b0);
        send(8'hE0);
        idle(99);
        send(8'h1C);
        // A full timeout drops the prefix.
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'hE0);
        idle(100);
        send(8'h1C);
        check("tmo_disp", disp, 16'h001C);
        check("tmo_ovf", ovf, 1'b0);
        drain("drain_timeout");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
